// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// PISO_PARITY_EN adds the ST_PARITY state.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT
`ifdef PISO_PARITY_EN
    , ST_PARITY
`endif
  } piso_state_t;

  // Bit counter width for a given word width; kept at least 1 bit wide.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module piso_bit_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, MSB first, valid/ready load handshake.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             frame_start_q;
  logic             accept;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CntW-1:0]  bitcnt;

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;
`endif

  // Ready only where a new word can start without a gap or an overwrite.
  always_comb begin
    load_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE:   load_ready = 1'b1;
`ifdef PISO_PARITY_EN
        ST_SHIFT:  load_ready = 1'b0;
        ST_PARITY: load_ready = 1'b1;
`else
        ST_SHIFT:  load_ready = cnt_zero;
`endif
        default:   load_ready = 1'b0;
      endcase
    end
  end

  assign accept  = load_valid && load_ready;
  assign cnt_dec = (state_q == ST_SHIFT) && !accept;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (cnt_zero) begin
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        state_d = accept ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      shreg_d = din;
`ifdef PISO_PARITY_EN
      parity_d = ^din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      frame_start_q <= accept;
`ifdef PISO_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  piso_bit_counter #(
    .Width(CntW)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .load_val(CntW'(WIDTH - 1)),
    .dec     (cnt_dec),
    .count   (bitcnt),
    .zero    (cnt_zero)
  );

  // Outputs decode registered state only.
  always_comb begin
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        sout        = shreg_q[WIDTH-1];
        sout_valid  = 1'b1;
        frame_start = frame_start_q;
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        sout       = parity_q;
        sout_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  logic unused_bitcnt;
  assign unused_bitcnt = ^bitcnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=4).
// Parity test runs only when PISO_PARITY_EN is defined.
module tb_piso_serializer;

  localparam int unsigned WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;

  int checks = 0;
  int errors = 0;

  piso_serializer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .din        (din),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".ready"}, 32'(load_ready), 32'd1);
    check_eq({tag, ".sout"}, 32'(sout), 32'd0);
    check_eq({tag, ".valid"}, 32'(sout_valid), 32'd0);
    check_eq({tag, ".fs"}, 32'(frame_start), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] b2b_bits;
  logic [3:0] basic_bits;
  logic [3:0] hold_bits;

  initial begin
    // Reset
    #1;
    check_eq("rst.ready", 32'(load_ready), 32'd0);
    tick();
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.valid", 32'(sout_valid), 32'd0);
    check_eq("rst.sout", 32'(sout), 32'd0);
    check_eq("rst.fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst.ready", 32'(load_ready), 32'd1);

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check_idle("idle");
      tick();
    end

    // Basic frame 1011
    basic_bits = 4'b1011;
    din = basic_bits;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    din = '0;
    for (int i = 0; i < 4; i++) begin
      check_eq("basic.sout", 32'(sout), 32'(basic_bits[3-i]));
      check_eq("basic.valid", 32'(sout_valid), 32'd1);
      check_eq("basic.fs", 32'(frame_start), 32'(i == 0));
      check_eq("basic.busy", 32'(busy), 32'd1);
      check_eq("basic.ready", 32'(load_ready), 32'((i == 3) && (FrameLen == WIDTH)));
      tick();
    end
    for (int i = WIDTH; i < FrameLen; i++) tick();
    check_eq("basic.busy_fall", 32'(busy), 32'd0);
    check_eq("basic.valid_fall", 32'(sout_valid), 32'd0);

`ifndef PISO_PARITY_EN
    // Back-to-back A then 5
    b2b_bits = 8'b1010_0101;
    din = 4'hA;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("b2b.sout", 32'(sout), 32'(b2b_bits[7-i]));
      check_eq("b2b.valid", 32'(sout_valid), 32'd1);
      check_eq("b2b.fs", 32'(frame_start), 32'((i == 0) || (i == 4)));
      if (i == 3) begin
        check_eq("b2b.ready", 32'(load_ready), 32'd1);
        din = 4'h5;
        load_valid = 1'b1;
      end
      tick();
      load_valid = 1'b0;
    end
    check_eq("b2b.end_valid", 32'(sout_valid), 32'd0);
    check_eq("b2b.end_busy", 32'(busy), 32'd0);

    // Hold-off: din toggles with load_valid high mid-frame
    hold_bits = 4'b0110;
    din = hold_bits;
    load_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("hold.sout", 32'(sout), 32'(hold_bits[3-i]));
      check_eq("hold.ready", 32'(load_ready), 32'(i == 3));
      din = (i % 2 == 0) ? 4'hF : 4'h0;
      load_valid = (i < 3);
      tick();
    end
    check_idle("hold.end");
`endif

    // Reset mid-frame of F
    din = 4'hF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check_eq("rstmid.bit1", 32'(sout), 32'd1);
    tick();
    check_eq("rstmid.bit2", 32'(sout), 32'd1);
    rst = 1'b1;
    load_valid = 1'b1;
    #1;
    check_eq("rstmid.ready_in_rst", 32'(load_ready), 32'd0);
    tick();
    check_eq("rstmid.valid", 32'(sout_valid), 32'd0);
    check_eq("rstmid.busy", 32'(busy), 32'd0);
    check_eq("rstmid.sout", 32'(sout), 32'd0);
    load_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("rstmid.ready_after", 32'(load_ready), 32'd1);
    tick();
    check_idle("rstmid.idle");

`ifdef PISO_PARITY_EN
    // Parity: 1011 -> 1,0,1,1,1 then 0011 trailing 0
    din = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("par1.sout", 32'(sout), 32'(5'b10111 >> (4 - i)) & 32'd1);
      check_eq("par1.valid", 32'(sout_valid), 32'd1);
      tick();
    end
    check_eq("par1.end", 32'(busy), 32'd0);
    din = 4'b0011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("par2.sout", 32'(sout), 32'(5'b00110 >> (4 - i)) & 32'd1);
      tick();
    end
    check_eq("par2.end", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
